// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) encoder/decoder pair.
// Bit positions follow the decoder's codeword ordering.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CW_W   = 7;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  localparam logic [2:0] ERR_POS_NONE = 3'd7;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/hamming74_parity_gen.sv
// Combinational Hamming(7,4) encoder; select=1 inverts every parity bit (odd parity).
// Also serves as the golden model in the decoder bench.
module hamming74_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic              select,
  output logic [CW_W-1:0]   cw
);

  logic p1;
  logic p2;
  logic p4;

  always_comb begin
    p1 = data[0] ^ data[1] ^ data[3] ^ select;
    p2 = data[0] ^ data[2] ^ data[3] ^ select;
    p4 = data[1] ^ data[2] ^ data[3] ^ select;

    cw         = '0;
    cw[P1_POS] = p1;
    cw[P2_POS] = p2;
    cw[D0_POS] = data[0];
    cw[P4_POS] = p4;
    cw[D1_POS] = data[1];
    cw[D2_POS] = data[2];
    cw[D3_POS] = data[3];
  end

endmodule

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) transmitter: encodes handshaken words, presents them in parallel and
// shifts them out LSB first, with an optional single-bit error injector for testing.
module hamming74_encoder_tx
  import hamming_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              err_inj_en,
  input  logic [2:0]        err_inj_pos,
  output logic [CW_W-1:0]   cw_out,
  output logic              cw_valid,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              busy,
  output logic [CNT_W-1:0]  cw_count
);

  localparam int               CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       LAST_BIT = 3'(CW_W - 1);

  state_t           state;
  logic [2:0]       bit_idx;
  logic [CYC_W-1:0] cyc;
  logic [CW_W-1:0]  clean_cw;
  logic [CW_W-1:0]  load_cw;
  logic             handshake;
  logic             bit_done;

  hamming74_parity_gen u_parity_gen (
    .data   (in_data),
    .select (select),
    .cw     (clean_cw)
  );

  // Injected flip is applied after encoding so the parity still reflects the clean data.
  always_comb begin
    load_cw = clean_cw;
    if (err_inj_en && (err_inj_pos != ERR_POS_NONE)) begin
      load_cw[err_inj_pos] = ~clean_cw[err_inj_pos];
    end
  end

  assign handshake = in_valid & in_ready;
  assign bit_done  = (cyc == CYC_LAST);

  // in_ready is only ever high in IDLE or the final clock of bit 6, so a handshake
  // always means "load the next word", optionally closing out the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      cyc       <= '0;
      in_ready  <= 1'b0;
      cw_out    <= '0;
      cw_valid  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      busy      <= 1'b0;
      cw_count  <= '0;
    end else begin
      cw_valid <= 1'b0;
      if (handshake) begin
        if (state == SHIFT) begin
          cw_count <= cw_count + CNT_W'(1);
        end
        state     <= SHIFT;
        bit_idx   <= '0;
        cyc       <= '0;
        cw_out    <= load_cw;
        cw_valid  <= 1'b1;
        ser_out   <= load_cw[0];
        ser_valid <= 1'b1;
        ser_sof   <= 1'b1;
        busy      <= 1'b1;
        in_ready  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            in_ready  <= 1'b1;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_sof   <= 1'b0;
            busy      <= 1'b0;
          end
          SHIFT: begin
            if (!bit_done) begin
              cyc      <= cyc + CYC_W'(1);
              in_ready <= (bit_idx == LAST_BIT) && ((cyc + CYC_W'(1)) == CYC_LAST);
            end else if (bit_idx != LAST_BIT) begin
              bit_idx  <= bit_idx + 3'd1;
              cyc      <= '0;
              ser_out  <= cw_out[bit_idx + 3'd1];
              ser_sof  <= 1'b0;
              in_ready <= ((bit_idx + 3'd1) == LAST_BIT) && (BIT_CYCLES == 1);
            end else begin
              cw_count  <= cw_count + CNT_W'(1);
              state     <= IDLE;
              bit_idx   <= '0;
              cyc       <= '0;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              ser_sof   <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Directed bench for hamming74_encoder_tx: one instance with BIT_CYCLES=1, one with
// BIT_CYCLES=3, checked against hand-computed codewords.
module tb_hamming74_encoder_tx;

  logic       clk;
  logic       rst;

  logic       select;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       err_inj_en;
  logic [2:0] err_inj_pos;
  logic [6:0] cw_out;
  logic       cw_valid;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_sof;
  logic       busy;
  logic [7:0] cw_count;

  logic       select_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic [3:0] in_data_b;
  logic       err_inj_en_b;
  logic [2:0] err_inj_pos_b;
  logic [6:0] cw_out_b;
  logic       cw_valid_b;
  logic       ser_out_b;
  logic       ser_valid_b;
  logic       ser_sof_b;
  logic       busy_b;
  logic [7:0] cw_count_b;

  int checks = 0;
  int errors = 0;

  hamming74_encoder_tx #(.BIT_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .select(select), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .err_inj_en(err_inj_en), .err_inj_pos(err_inj_pos),
    .cw_out(cw_out), .cw_valid(cw_valid), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_sof(ser_sof), .busy(busy), .cw_count(cw_count)
  );

  hamming74_encoder_tx #(.BIT_CYCLES(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .select(select_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .err_inj_en(err_inj_en_b), .err_inj_pos(err_inj_pos_b),
    .cw_out(cw_out_b), .cw_valid(cw_valid_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .ser_sof(ser_sof_b), .busy(busy_b), .cw_count(cw_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic s, input logic e, input logic [2:0] p);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      stepClk();
      guard++;
    end
    checkOutput("ready_wait", 32'(in_ready), 32'd1);
    in_data     = d;
    select      = s;
    err_inj_en  = e;
    err_inj_pos = p;
    in_valid    = 1'b1;
    stepClk();
    in_valid    = 1'b0;
    err_inj_en  = 1'b0;
  endtask

  logic [3:0] vData [5] = '{4'b1011, 4'b0000, 4'b0000, 4'b1011, 4'b1011};
  logic       vSel  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       vEn   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] vPos  [5] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd7};
  logic [6:0] vCw   [5] = '{7'h5E, 7'h0B, 7'h00, 7'h45, 7'h55};
  logic [6:0] bbCw  [3] = '{7'h07, 7'h19, 7'h1E};

  initial begin
    logic [6:0] expCw;
    int         guard;

    rst = 1'b1;
    select = 0; in_valid = 0; in_data = 0; err_inj_en = 0; err_inj_pos = 0;
    select_b = 0; in_valid_b = 0; in_data_b = 0; err_inj_en_b = 0; err_inj_pos_b = 0;
    repeat (2) stepClk();

    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_cw_out", 32'(cw_out), 32'd0);
    checkOutput("rst_cw_valid", 32'(cw_valid), 32'd0);
    checkOutput("rst_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cw_count", 32'(cw_count), 32'd0);

    rst = 1'b0;
    stepClk();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_cw_valid", 32'(cw_valid), 32'd0);

    $display("[TB] basic even-parity frame");
    expCw = 7'h55;
    applyStimulus(4'b1011, 1'b0, 1'b0, 3'd0);
    checkOutput("t1_cw_out", 32'(cw_out), 32'(expCw));
    for (int k = 0; k < 7; k++) begin
      checkOutput("t1_ser_out", 32'(ser_out), 32'(expCw[k]));
      checkOutput("t1_ser_sof", 32'(ser_sof), 32'(k == 0));
      checkOutput("t1_ser_valid", 32'(ser_valid), 32'd1);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      checkOutput("t1_cw_valid", 32'(cw_valid), 32'(k == 0));
      stepClk();
    end
    checkOutput("t1_idle_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_cw_count", 32'(cw_count), 32'd1);
    checkOutput("t1_idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] parity modes and error injection");
    for (int v = 0; v < 5; v++) begin
      expCw = vCw[v];
      applyStimulus(vData[v], vSel[v], vEn[v], vPos[v]);
      checkOutput("vec_cw_out", 32'(cw_out), 32'(expCw));
      checkOutput("vec_cw_valid", 32'(cw_valid), 32'd1);
      for (int k = 0; k < 7; k++) begin
        checkOutput("vec_ser_out", 32'(ser_out), 32'(expCw[k]));
        stepClk();
      end
    end
    checkOutput("vec_cw_count", 32'(cw_count), 32'd6);

    $display("[TB] back-to-back words");
    in_data  = 4'd1;
    select   = 1'b0;
    in_valid = 1'b1;
    stepClk();
    for (int c = 0; c < 21; c++) begin
      int w;
      int b;
      w = c / 7;
      b = c % 7;
      expCw = bbCw[w];
      checkOutput("bb_ser_valid", 32'(ser_valid), 32'd1);
      checkOutput("bb_ser_out", 32'(ser_out), 32'(expCw[b]));
      checkOutput("bb_in_ready", 32'(in_ready), 32'(b == 6));
      if (b == 0) begin
        checkOutput("bb_cw_out", 32'(cw_out), 32'(expCw));
        checkOutput("bb_cw_valid", 32'(cw_valid), 32'd1);
      end
      if (b == 6) begin
        if (w < 2) in_data = 4'(w + 2);
        else in_valid = 1'b0;
      end
      stepClk();
    end
    checkOutput("bb_end_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("bb_cw_count", 32'(cw_count), 32'd9);

    $display("[TB] BIT_CYCLES=3 frame with mid-frame select change");
    expCw = 7'h55;
    guard = 0;
    while (!in_ready_b && guard < 100) begin
      stepClk();
      guard++;
    end
    checkOutput("b_ready_wait", 32'(in_ready_b), 32'd1);
    in_data_b  = 4'b1011;
    select_b   = 1'b0;
    in_valid_b = 1'b1;
    stepClk();
    in_valid_b = 1'b0;
    select_b   = 1'b1;
    in_data_b  = 4'b0110;
    checkOutput("b_cw_out", 32'(cw_out_b), 32'(expCw));
    checkOutput("b_cw_valid", 32'(cw_valid_b), 32'd1);
    for (int c = 0; c < 21; c++) begin
      checkOutput("b_ser_out", 32'(ser_out_b), 32'(expCw[c / 3]));
      checkOutput("b_ser_sof", 32'(ser_sof_b), 32'(c < 3));
      checkOutput("b_ser_valid", 32'(ser_valid_b), 32'd1);
      checkOutput("b_in_ready", 32'(in_ready_b), 32'(c == 20));
      if (c == 10) select_b = 1'b0;
      stepClk();
    end
    checkOutput("b_end_ser_valid", 32'(ser_valid_b), 32'd0);
    checkOutput("b_cw_count", 32'(cw_count_b), 32'd1);
    checkOutput("b_cw_out_hold", 32'(cw_out_b), 32'(expCw));

    $display("[TB] reset mid-frame");
    applyStimulus(4'b1011, 1'b0, 1'b0, 3'd0);
    repeat (3) stepClk();
    checkOutput("mid_ser_valid", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    stepClk();
    checkOutput("mid_rst_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("mid_rst_ser_out", 32'(ser_out), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_cw_out", 32'(cw_out), 32'd0);
    checkOutput("mid_rst_cw_count", 32'(cw_count), 32'd0);
    rst = 1'b0;
    stepClk();
    checkOutput("mid_post_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_post_ser_valid", 32'(ser_valid), 32'd0);

    $display("[TB] 256-word counter wrap");
    in_data  = 4'b0101;
    select   = 1'b0;
    in_valid = 1'b1;
    stepClk();
    for (int i = 0; i < 1792; i++) begin
      if (i == 1785) checkOutput("wrap_count_255", 32'(cw_count), 32'd255);
      if (i == 1791) in_valid = 1'b0;
      stepClk();
    end
    checkOutput("wrap_cw_count", 32'(cw_count), 32'd0);
    checkOutput("wrap_ser_valid", 32'(ser_valid), 32'd0);
    checkOutput("wrap_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
